// File: rtl/jzjcoref_loader_pkg.sv
// jzjcoref_loader_pkg: loader FSM states and frame constants shared by the loader files
package jzjcoref_loader_pkg;
    typedef enum logic [2:0] {IDLE, COUNT_LO, COUNT_HI, DATA, CHECK, DONE, ERROR} loader_state_t;
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int LOADER_WORD_BYTES = 4;
endpackage

// File: rtl/jzjcoref_loader_word_assembler.sv
// jzjcoref_loader_word_assembler: packs little-endian bytes into words and keeps the running XOR checksum
module jzjcoref_loader_word_assembler
    import jzjcoref_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [7:0]  checksum
);
    logic [23:0] partial;
    logic [1:0]  byte_idx;
    // the fourth byte completes the word combinationally so the top can register it on the same edge
    assign word = {byte_data, partial};
    assign word_ready = shift_en && byte_idx == 2'(LOADER_WORD_BYTES - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            partial  <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (clear) begin
            partial  <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (shift_en) begin
            partial  <= {byte_data, partial[23:8]};
            byte_idx <= byte_idx + 2'd1;
            checksum <= checksum ^ byte_data;
        end
    end
endmodule

// File: rtl/jzjcoref_mem_loader.sv
// jzjcoref_mem_loader: streams a framed program image into core memory and holds the core in reset until it checks out
module jzjcoref_mem_loader
    import jzjcoref_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] MAGIC      = LOADER_MAGIC
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;
    loader_state_t         state, state_d;
    logic                  accept, clear, word_ready;
    logic [7:0]            count_lo, checksum;
    logic [15:0]           count, words_left;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           word;
    assign byte_ready = !reset;
    assign accept = byte_valid && byte_ready;
    assign count = {byte_data, count_lo};
    assign clear = accept && byte_data == MAGIC && (state == IDLE || state == DONE || state == ERROR);
    jzjcoref_loader_word_assembler u_asm (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .shift_en(accept && state == DATA),
        .byte_data(byte_data),
        .word(word),
        .word_ready(word_ready),
        .checksum(checksum)
    );
    always_comb begin
        state_d = state;
        if (clear)
            state_d = COUNT_LO;
        else if (accept)
            case (state)
                COUNT_LO: state_d = COUNT_HI;
                COUNT_HI: state_d = count == 16'd0 ? CHECK : {17'd0, count} > MAX_WORDS ? ERROR : DATA;
                DATA:     state_d = word_ready && words_left == 16'd1 ? CHECK : DATA;
                CHECK:    state_d = byte_data == checksum ? DONE : ERROR;
                default:  state_d = state;
            endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            count_lo         <= '0;
            words_left       <= '0;
            word_idx         <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            core_reset       <= 1'b1;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            state            <= state_d;
            mem_write_enable <= word_ready;
            core_reset       <= state_d != DONE;
            load_done        <= state_d == DONE;
            load_error       <= state_d == ERROR;
            if (accept && state == COUNT_LO)
                count_lo <= byte_data;
            if (accept && state == COUNT_HI)
                words_left <= count;
            // count never exceeds MAX_WORDS here, so word_idx only wraps after the last write of a frame
            if (clear)
                word_idx <= '0;
            else if (word_ready) begin
                word_idx       <= word_idx + ADDR_WIDTH'(1);
                words_left     <= words_left - 16'd1;
                mem_address    <= word_idx;
                mem_write_data <= word;
            end
        end
    end
endmodule

// File: tb/tb_jzjcoref_mem_loader.sv
// tb_jzjcoref_mem_loader: random and directed frames checked against frame-level expectations on two loader widths
module tb_jzjcoref_mem_loader;
    localparam logic [7:0] MAGIC = 8'hA5;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  bv, br, we, cr, ld, le;
    logic [7:0]  bd0, bd1;
    logic [11:0] a0;
    logic [1:0]  a1;
    logic [31:0] wd0, wd1;
    int          n_cmp = 0, n_err = 0;
    int          wcnt0 = 0, wcnt1 = 0;

    always #5 clock = ~clock;

    jzjcoref_mem_loader #(.ADDR_WIDTH(12), .MAGIC(8'hA5)) u_big (
        .clock(clock), .reset(reset), .byte_valid(bv[0]), .byte_data(bd0), .byte_ready(br[0]),
        .mem_write_enable(we[0]), .mem_address(a0), .mem_write_data(wd0),
        .core_reset(cr[0]), .load_done(ld[0]), .load_error(le[0])
    );
    jzjcoref_mem_loader #(.ADDR_WIDTH(2), .MAGIC(8'hA5)) u_small (
        .clock(clock), .reset(reset), .byte_valid(bv[1]), .byte_data(bd1), .byte_ready(br[1]),
        .mem_write_enable(we[1]), .mem_address(a1), .mem_write_data(wd1),
        .core_reset(cr[1]), .load_done(ld[1]), .load_error(le[1])
    );

    always @(negedge clock) begin
        if (we[0] === 1'b1) wcnt0++;
        if (we[1] === 1'b1) wcnt1++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input int s);
        return s == 0 ? 32'(a0) : 32'(a1);
    endfunction

    function automatic logic [31:0] data_of(input int s);
        return s == 0 ? wd0 : wd1;
    endfunction

    function automatic int wcnt(input int s);
        return s == 0 ? wcnt0 : wcnt1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input int gap);
        repeat (gap) tick();
        bv[s] = 1'b1;
        if (s == 0) bd0 = b; else bd1 = b;
        tick();
        bv[s] = 1'b0;
    endtask

    task automatic check_idle_reset(input int s);
        check("rst_byte_ready", br[s], 0);
        check("rst_we", we[s], 0);
        check("rst_addr", addr_of(s), 0);
        check("rst_data", data_of(s), 0);
        check("rst_core_reset", cr[s], 1);
        check("rst_done", ld[s], 0);
        check("rst_error", le[s], 0);
    endtask

    // Expected outcome per frame: words i = bytes 4i..4i+3 LE at address i,
    // done iff count fits and checksum byte equals XOR of data bytes.
    task automatic send_frame(input int s, input int n, input logic [7:0] data[$], input logic [7:0] chk,
                              input int gmin, input int gmax, input logic [7:0] garbage[$]);
        int         max_words = s == 0 ? 4096 : 4;
        int         base;
        logic [7:0] x = 8'h00;
        logic       good;
        foreach (garbage[g]) send_byte(s, garbage[g], $urandom_range(gmin, gmax));
        base = wcnt(s);
        send_byte(s, MAGIC, $urandom_range(gmin, gmax));
        check("magic_core_reset", cr[s], 1);
        check("magic_done", ld[s], 0);
        check("magic_error", le[s], 0);
        send_byte(s, n[7:0], $urandom_range(gmin, gmax));
        send_byte(s, n[15:8], $urandom_range(gmin, gmax));
        if (n > max_words) begin
            check("oversize_error", le[s], 1);
            check("oversize_core_reset", cr[s], 1);
            check("oversize_done", ld[s], 0);
            tick();
            check("oversize_writes", wcnt(s) - base, 0);
            return;
        end
        for (int i = 0; i < n * 4; i++) begin
            x ^= data[i];
            send_byte(s, data[i], $urandom_range(gmin, gmax));
            if (i % 4 == 3) begin
                check("strobe", we[s], 1);
                check("addr", addr_of(s), i / 4);
                check("wdata", data_of(s), {data[i], data[i-1], data[i-2], data[i-3]});
            end else
                check("no_strobe", we[s], 0);
        end
        good = chk == x;
        send_byte(s, chk, $urandom_range(gmin, gmax));
        check("after_chk_strobe", we[s], 0);
        tick();
        check("writes", wcnt(s) - base, n);
        check("done", ld[s], good);
        check("error", le[s], !good);
        check("core_reset", cr[s], !good);
    endtask

    task automatic random_frame(input int s, input int n, input logic corrupt);
        logic [7:0] d[$];
        logic [7:0] g[$];
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        for (int i = 0; i < n * 4; i++) begin
            b = 8'($urandom);
            d.push_back(b);
            x ^= b;
        end
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            b = 8'($urandom);
            g.push_back(b == MAGIC ? 8'h00 : b);
        end
        if (corrupt) x ^= 8'h01 << $urandom_range(0, 7);
        send_frame(s, n, d, x, 0, 2, g);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] none[$];
        logic [7:0] junk[$];
        bv = 2'b00;
        bd0 = 8'h00;
        bd1 = 8'h00;
        repeat (2) tick();
        check_idle_reset(0);
        check_idle_reset(1);
        reset = 1'b0;
        #1;
        check("byte_ready_big", br[0], 1);
        check("byte_ready_small", br[1], 1);
        tick();

        d = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(0, 1, d, 8'h08, 0, 0, none);
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hB6, 8'hC7, 8'hD8};
        send_frame(0, 2, d, 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'hA5 ^ 8'hB6 ^ 8'hC7 ^ 8'hD8, 3, 3, none);
        d = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(0, 1, d, 8'h09, 0, 0, none);
        junk = '{8'h00, 8'hFF, 8'h13};
        send_frame(0, 0, none, 8'h00, 0, 0, junk);

        send_frame(1, 5, none, 8'h00, 0, 0, none);
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(8'(i * 17 + 3));
        send_frame(1, 4, d, 8'h00 ^ 8'h00, 0, 1, none);
        random_frame(1, 4, 1'b0);

        send_byte(0, MAGIC, 0);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'hEE, 0);
        send_byte(0, 8'hDD, 0);
        reset = 1'b1;
        #1;
        check("midrst_we", we[0], 0);
        check("midrst_byte_ready", br[0], 0);
        check("midrst_core_reset", cr[0], 1);
        tick();
        reset = 1'b0;
        tick();
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(0, 1, d, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0, 0, none);

        for (int k = 0; k < 30; k++)
            random_frame(0, $urandom_range(0, 6), $urandom_range(0, 3) == 0);
        for (int k = 0; k < 10; k++)
            random_frame(1, $urandom_range(0, 6), $urandom_range(0, 3) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
